// File: rtl/sregfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sregfile_mp                                                     |
// | Purpose  : Multi-port scalar register file with per-register busy          |
// |            scoreboard. Optional write-to-read forwarding under the macro   |
// |            SREGFILE_MP_BYPASS_EN.                                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sregfile_mp #(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_COUNT    = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_RD_PORTS*$clog2(REG_COUNT)-1:0] rd_addr_i,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]    rd_data_o,
  output logic [NUM_RD_PORTS-1:0]               rd_busy_o,
  input  logic [NUM_WR_PORTS-1:0]               wr_en_i,
  input  logic [NUM_WR_PORTS*$clog2(REG_COUNT)-1:0] wr_addr_i,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0]    wr_data_i,
  input  logic                                  rsv_en_i,
  input  logic [$clog2(REG_COUNT)-1:0]          rsv_addr_i,
  output logic [REG_COUNT-1:0]                  busy_o
);

  localparam int ADDR_W = $clog2(REG_COUNT);

  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
  logic [REG_COUNT-1:0]  r_busy;
  logic [REG_COUNT-1:0]  w_busy_next;

  logic [ADDR_W-1:0]     w_wr_addr [NUM_WR_PORTS];
  logic [DATA_WIDTH-1:0] w_wr_data [NUM_WR_PORTS];
  logic                  w_wr_vld  [NUM_WR_PORTS];

  generate
    for (genvar w = 0; w < NUM_WR_PORTS; w++) begin : g_wr
      assign w_wr_addr[w] = wr_addr_i[w*ADDR_W +: ADDR_W];
      assign w_wr_data[w] = wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
      assign w_wr_vld[w]  = wr_en_i[w] && (w_wr_addr[w] != '0);
    end
  endgenerate

  // Writes clear first, then the reservation sets, so a same-cycle new producer wins.
  always_comb begin
    w_busy_next = r_busy;
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      if (w_wr_vld[w]) w_busy_next[w_wr_addr[w]] = 1'b0;
    end
    if (rsv_en_i && (rsv_addr_i != '0)) w_busy_next[rsv_addr_i] = 1'b1;
  end

  // Later loop iterations override earlier ones, giving highest-port priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_COUNT; r++) r_regs[r] <= '0;
      r_busy <= '0;
    end else begin
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
        if (w_wr_vld[w]) r_regs[w_wr_addr[w]] <= w_wr_data[w];
      end
      r_busy <= w_busy_next;
    end
  end

  assign busy_o = r_busy;

  generate
    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
      logic [ADDR_W-1:0]     w_addr;
      logic [DATA_WIDTH-1:0] w_data;
      logic                  w_busy;

      assign w_addr = rd_addr_i[p*ADDR_W +: ADDR_W];

      always_comb begin
        w_data = (w_addr == '0) ? '0 : r_regs[w_addr];
        w_busy = r_busy[w_addr];
`ifdef SREGFILE_MP_BYPASS_EN
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
          if (w_wr_vld[w] && (w_wr_addr[w] == w_addr)) begin
            w_data = w_wr_data[w];
            w_busy = rsv_en_i && (rsv_addr_i == w_addr);
          end
        end
`endif
      end

      assign rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = w_data;
      assign rd_busy_o[p]                          = w_busy;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sregfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sregfile_mp                                                  |
// | Purpose  : Directed self-checking bench for sregfile_mp (default params).  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sregfile_mp;

  localparam int DW = 32;
  localparam int RC = 32;
  localparam int AW = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [2*AW-1:0] rd_addr_i;
  logic [2*DW-1:0] rd_data_o;
  logic [1:0]      rd_busy_o;
  logic [1:0]      wr_en_i;
  logic [2*AW-1:0] wr_addr_i;
  logic [2*DW-1:0] wr_data_i;
  logic            rsv_en_i;
  logic [AW-1:0]   rsv_addr_i;
  logic [RC-1:0]   busy_o;

  int n_checks = 0;
  int n_fails  = 0;

  sregfile_mp #(
    .DATA_WIDTH  (DW),
    .REG_COUNT   (RC),
    .NUM_RD_PORTS(2),
    .NUM_WR_PORTS(2)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o),
    .rd_busy_o (rd_busy_o),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rsv_en_i  (rsv_en_i),
    .rsv_addr_i(rsv_addr_i),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst       = 1'b0;
    wr_en_i   = '0;
    wr_addr_i = '0;
    wr_data_i = '0;
    rsv_en_i  = 1'b0;
    rsv_addr_i = '0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr_i = {a1, a0};
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en_i[port]            = 1'b1;
    wr_addr_i[port*AW +: AW] = a;
    wr_data_i[port*DW +: DW] = d;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    rsv_en_i   = 1'b1;
    rsv_addr_i = a;
  endtask

  // Commit current stimulus at the next edge, then return to idle inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  initial begin
    idle();
    rd(0, 0);
    rst = 1'b1;
    tick();

    rd(5, 31);
    #1;
    chk("reset_rd0", rd_data_o[31:0], 64'h0);
    chk("reset_rd1", rd_data_o[63:32], 64'h0);
    chk("reset_busy", busy_o, 64'h0);
    chk("reset_rdbusy", rd_busy_o, 64'h0);

    wr(0, 3, 32'hDEADBEEF);
    tick();
    rd(0, 3);
    #1;
    chk("wr_x3_p1", rd_data_o[63:32], 64'hDEADBEEF);

    wr(0, 0, 32'h1234);
    tick();
    rd(0, 3);
    #1;
    chk("wr_x0_dropped", rd_data_o[31:0], 64'h0);

    wr(0, 7, 32'h11111111);
    wr(1, 7, 32'h22222222);
    tick();
    rd(7, 7);
    #1;
    chk("conflict_p0", rd_data_o[31:0], 64'h22222222);
    chk("conflict_p1", rd_data_o[63:32], 64'h22222222);

    wr(0, 10, 32'hAAAA0001);
    wr(1, 11, 32'hBBBB0002);
    tick();
    rd(10, 11);
    #1;
    chk("dual_wr_x10", rd_data_o[31:0], 64'hAAAA0001);
    chk("dual_wr_x11", rd_data_o[63:32], 64'hBBBB0002);

    rsv(9);
    tick();
    rd(9, 3);
    #1;
    chk("rsv_busy_vec", busy_o, 64'h200);
    chk("rsv_rdbusy", rd_busy_o, 64'h1);

    wr(1, 9, 32'h5);
    tick();
    rd(9, 9);
    #1;
    chk("clr_busy_vec", busy_o, 64'h0);
    chk("clr_data", rd_data_o[31:0], 64'h5);

    rsv(9);
    wr(0, 9, 32'h6);
    tick();
    rd(9, 9);
    #1;
    chk("rsv_wr_busy", busy_o, 64'h200);
    chk("rsv_wr_data", rd_data_o[63:32], 64'h6);
    chk("rsv_wr_rdbusy", rd_busy_o, 64'h3);

    rsv(9);
    tick();
    #1;
    chk("rsv_again", busy_o, 64'h200);

    rsv(0);
    tick();
    rd(0, 0);
    #1;
    chk("rsv_x0", busy_o, 64'h200);
    chk("rd_x0_busy", rd_busy_o, 64'h0);

    rsv(4);
    wr(0, 4, 32'hAA);
    tick();
    rd(4, 9);
    #1;
    chk("pre_rst_x4", rd_data_o[31:0], 64'hAA);
    chk("pre_rst_busy", busy_o, 64'h210);

    rst = 1'b1;
    wr(1, 4, 32'hBB);
    rsv(5);
    tick();
    rd(4, 3);
    #1;
    chk("mid_rst_x4", rd_data_o[31:0], 64'h0);
    chk("mid_rst_x3", rd_data_o[63:32], 64'h0);
    chk("mid_rst_busy", busy_o, 64'h0);

    wr(0, 12, 32'h1);
    rsv(12);
    tick();
    rd(12, 12);
    wr(0, 12, 32'hCAFEF00D);
    #1;
`ifdef SREGFILE_MP_BYPASS_EN
    chk("byp_data", rd_data_o[31:0], 64'hCAFEF00D);
    chk("byp_rdbusy", rd_busy_o, 64'h0);
`else
    chk("nobyp_data", rd_data_o[31:0], 64'h1);
    chk("nobyp_rdbusy", rd_busy_o, 64'h3);
`endif
    tick();
    rd(12, 12);
    #1;
    chk("post_wr_x12", rd_data_o[63:32], 64'hCAFEF00D);
    chk("post_wr_busy", busy_o, 64'h0);

    rd(13, 0);
    wr(0, 13, 32'h1);
    wr(1, 13, 32'h2);
    wr(1, 0, 32'h2);
    wr(1, 13, 32'h2);
    rsv(13);
    #1;
`ifdef SREGFILE_MP_BYPASS_EN
    chk("byp_hi_port", rd_data_o[31:0], 64'h2);
    chk("byp_rsv_busy", rd_busy_o, 64'h1);
`else
    chk("nobyp_old", rd_data_o[31:0], 64'h0);
    chk("nobyp_busy", rd_busy_o, 64'h0);
`endif
    chk("same_cyc_x0", rd_data_o[63:32], 64'h0);
    tick();
    rd(13, 13);
    #1;
    chk("x13_commit", rd_data_o[31:0], 64'h2);
    chk("x13_busy", busy_o, 64'h2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
